// File: rtl/noc_merge_arbiter.sv
// Two-input round-robin flit merge with a registered output stage and
// per-input saturating grant counters.

module noc_merge_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);
  // Clear wins over a same-cycle increment, so that grant goes uncounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (inc && cnt != {CW{1'b1}})  cnt <= cnt + 1'b1;
  end
endmodule

module noc_merge_arbiter #(
  parameter int W  = 9,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [W-1:0]  in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [W-1:0]  in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_src,
  input  logic          out_ready,
  input  logic          clr_cnt,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);
  logic                 prio;
  logic [1:0]           vld, gnt, inc;
  logic                 load, xfer, sel;
  logic [1:0][CW-1:0]   cnt;

  assign vld = {in1_valid, in0_valid};

  always_comb begin
    gnt = 2'b00;
    case (vld)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  assign load = !out_valid || out_ready;
  assign xfer = load && (gnt != 2'b00);
  assign sel  = gnt[1];

  // Readies are forced low during reset so nothing is accepted then.
  assign in0_ready = rst_n && load && gnt[0];
  assign in1_ready = rst_n && load && gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel ? in1_data : in0_data;
      out_src   <= sel;
      prio      <= !sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign inc = xfer ? gnt : 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    noc_merge_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .clr   (clr_cnt),
      .cnt   (cnt[i])
    );
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule

// File: tb/tb_noc_merge_arbiter.sv
// Directed table-driven bench for noc_merge_arbiter plus hand sequences for
// async reset and counter saturation (second instance with CW=2).

module tb_noc_merge_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0, v1, r0, r1, ov, src, ordy, clr;
  logic [8:0] d0, d1, od;
  logic [7:0] c0, c1;

  logic       sv0, sv1, sr0, sr1, sov, ssrc, sordy, sclr;
  logic [8:0] sd0, sd1, sod;
  logic [1:0] sc0, sc1;

  noc_merge_arbiter #(.W(9), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(v0), .in0_data(d0), .in0_ready(r0),
    .in1_valid(v1), .in1_data(d1), .in1_ready(r1),
    .out_valid(ov), .out_data(od), .out_src(src), .out_ready(ordy),
    .clr_cnt(clr), .cnt0(c0), .cnt1(c1)
  );

  noc_merge_arbiter #(.W(9), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(sv0), .in0_data(sd0), .in0_ready(sr0),
    .in1_valid(sv1), .in1_data(sd1), .in1_ready(sr1),
    .out_valid(sov), .out_data(sod), .out_src(ssrc), .out_ready(sordy),
    .clr_cnt(sclr), .cnt0(sc0), .cnt1(sc1)
  );

  typedef struct {
    logic       v0; logic [8:0] d0;
    logic       v1; logic [8:0] d1;
    logic       ordy; logic clr;
    logic       r0; logic r1;
    logic       ov; logic [8:0] od; logic src;
    logic [7:0] c0; logic [7:0] c1;
  } vec_t;

  vec_t vt[15];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int i);
    v0 = vt[i].v0; d0 = vt[i].d0; v1 = vt[i].v1; d1 = vt[i].d1;
    ordy = vt[i].ordy; clr = vt[i].clr;
    #1;
    chk($sformatf("v%0d in0_ready", i), {31'd0, r0}, {31'd0, vt[i].r0});
    chk($sformatf("v%0d in1_ready", i), {31'd0, r1}, {31'd0, vt[i].r1});
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", i), {31'd0, ov}, {31'd0, vt[i].ov});
    chk($sformatf("v%0d out_data", i), {23'd0, od}, {23'd0, vt[i].od});
    chk($sformatf("v%0d out_src", i), {31'd0, src}, {31'd0, vt[i].src});
    chk($sformatf("v%0d cnt0", i), {24'd0, c0}, {24'd0, vt[i].c0});
    chk($sformatf("v%0d cnt1", i), {24'd0, c1}, {24'd0, vt[i].c1});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    //          v0 d0      v1 d1      ordy clr r0 r1 ov od      src c0 c1
    // in0 only, then idle drain
    vt[0]  = '{1, 9'h1A3, 0, 9'h000, 1, 0, 1, 0, 1, 9'h1A3, 0, 1, 0};
    vt[1]  = '{1, 9'h0F0, 0, 9'h000, 1, 0, 1, 0, 1, 9'h0F0, 0, 2, 0};
    vt[2]  = '{0, 9'h000, 0, 9'h000, 1, 0, 0, 0, 0, 9'h0F0, 0, 2, 0};
    // contention from reset prio: 0,1,0,1,0,1
    vt[3]  = '{1, 9'h101, 1, 9'h1F1, 1, 0, 1, 0, 1, 9'h101, 0, 1, 0};
    vt[4]  = '{1, 9'h102, 1, 9'h1F1, 1, 0, 0, 1, 1, 9'h1F1, 1, 1, 1};
    vt[5]  = '{1, 9'h102, 1, 9'h1F2, 1, 0, 1, 0, 1, 9'h102, 0, 2, 1};
    vt[6]  = '{1, 9'h103, 1, 9'h1F2, 1, 0, 0, 1, 1, 9'h1F2, 1, 2, 2};
    vt[7]  = '{1, 9'h103, 1, 9'h1F3, 1, 0, 1, 0, 1, 9'h103, 0, 3, 2};
    vt[8]  = '{1, 9'h104, 1, 9'h1F3, 1, 0, 0, 1, 1, 9'h1F3, 1, 3, 3};
    // backpressure x4, then release drains and loads same cycle
    vt[9]  = '{1, 9'h104, 1, 9'h1F4, 0, 0, 0, 0, 1, 9'h1F3, 1, 3, 3};
    vt[10] = vt[9]; vt[11] = vt[9]; vt[12] = vt[9];
    vt[13] = '{1, 9'h104, 1, 9'h1F4, 1, 0, 1, 0, 1, 9'h104, 0, 4, 3};
    // single stall with only in1 pending: pointer must not move
    vt[14] = '{0, 9'h000, 1, 9'h1F4, 0, 0, 0, 0, 1, 9'h104, 0, 4, 3};

    v0 = 1; v1 = 1; d0 = 9'h155; d1 = 9'h0AA; ordy = 1; clr = 0;
    sv0 = 0; sv1 = 0; sd0 = 0; sd1 = 0; sordy = 1; sclr = 0;
    #12;
    chk("rst in0_ready", {31'd0, r0}, 32'd0);
    chk("rst in1_ready", {31'd0, r1}, 32'd0);
    chk("rst out_valid", {31'd0, ov}, 32'd0);
    chk("rst out_data", {23'd0, od}, 32'd0);
    chk("rst out_src", {31'd0, src}, 32'd0);
    chk("rst cnt0", {24'd0, c0}, 32'd0);
    chk("rst cnt1", {24'd0, c1}, 32'd0);
    v0 = 0; v1 = 0;
    do_reset();

    for (int i = 0; i < 3; i++) run_vec(i);
    do_reset();
    for (int i = 3; i < 15; i++) run_vec(i);

    // prio is 1 here: both valid picks in1; clr overrides that grant's count
    v0 = 1; d0 = 9'h105; v1 = 1; d1 = 9'h1F4; ordy = 1; clr = 1;
    #1;
    chk("prio hold in1_ready", {31'd0, r1}, 32'd1);
    chk("prio hold in0_ready", {31'd0, r0}, 32'd0);
    @(posedge clk); #1;
    clr = 0;
    chk("clr out_data", {23'd0, od}, 32'h1F4);
    chk("clr cnt0", {24'd0, c0}, 32'd0);
    chk("clr cnt1", {24'd0, c1}, 32'd0);

    // async reset between edges with a flit held; prio was 0 now, force it to 1 first
    v1 = 0; d0 = 9'h1AA;
    @(posedge clk); #1;
    chk("pre-rst out_valid", {31'd0, ov}, 32'd1);
    chk("pre-rst cnt0", {24'd0, c0}, 32'd1);
    v0 = 1; v1 = 1; ordy = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, ov}, 32'd0);
    chk("arst out_data", {23'd0, od}, 32'd0);
    chk("arst cnt0", {24'd0, c0}, 32'd0);
    chk("arst in0_ready", {31'd0, r0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst prio in0_ready", {31'd0, r0}, 32'd1);
    chk("arst prio in1_ready", {31'd0, r1}, 32'd0);
    v0 = 0; v1 = 0;
    @(posedge clk); #1;

    // saturation on the CW=2 instance
    sv1 = 1;
    for (int k = 0; k < 5; k++) begin
      sd1 = 9'(9'h040 + k);
      @(posedge clk); #1;
      chk($sformatf("sat cnt1 k%0d", k), {30'd0, sc1}, (k < 3) ? (k + 1) : 3);
      chk($sformatf("sat out_data k%0d", k), {23'd0, sod}, 32'(9'h040 + k));
    end
    sclr = 1;
    @(posedge clk); #1;
    sclr = 0;
    chk("sat clr cnt1", {30'd0, sc1}, 32'd0);
    chk("sat clr out_src", {31'd0, ssrc}, 32'd1);
    @(posedge clk); #1;
    chk("sat post-clr cnt1", {30'd0, sc1}, 32'd1);
    sv1 = 0;
    @(posedge clk); #1;
    chk("sat idle out_valid", {31'd0, sov}, 32'd0);
    chk("sat idle cnt1", {30'd0, sc1}, 32'd1);
    chk("sat cnt0", {30'd0, sc0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
